// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the sequencer: icodes, sequencer states, status
// codes and the memory-op class helpers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEMORY     = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_UPDATE_PC  = 3'd5,
    S_IDLE       = 3'd6,
    S_HALT       = 3'd7
  } state_e;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the ram handshake and flags a timeout on the
// last allowed waiting cycle; MEM_TIMEOUT=0 disables the flag.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= cnt + WAIT_W'(1);
  end

  assign timeout = (MEM_TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle Y86-64 sequencer: walks each instruction through the datapath
// stages, drives ram requests, tracks architectural status and retirements.
//
// state      | meaning
// FETCH      | instruction read from ram, wait for mem_ready_i
// DECODE     | regfile read strobe
// EXECUTE    | ALU / CC update strobe
// MEMORY     | data read or write, wait for mem_ready_i
// WRITE_BACK | regfile write
// UPDATE_PC  | PC update, retire, pick next state from run_i / IHALT
// IDLE       | parked, waiting for run_i
// HALT       | absorbing fault/halt state, left only by reset
module cpu_seq_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned WAIT_W      = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             mem_ready_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             dmem_error_i,
  output logic [2:0]       state_o,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             execute_en_o,
  output logic             memory_en_o,
  output logic             wb_en_o,
  output logic             pc_en_o,
  output logic             ram_read_en_o,
  output logic             ram_write_en_o,
  output logic             ram_read_instruction_o,
  output logic             addr_sel_o,
  output logic [2:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_count_o
);

  state_e           state;
  logic [2:0]       stat;
  logic [3:0]       icode_q;
  logic [CNT_W-1:0] instr_count;
  logic             in_wait;
  logic             timeout;

  // Counter restarts whenever we are outside a wait state or the request completes.
  assign in_wait = (state == S_FETCH) || (state == S_MEMORY);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .WAIT_W     (WAIT_W)
  ) u_wait (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .clr    (!in_wait || mem_ready_i),
    .en     (in_wait && !mem_ready_i),
    .timeout(timeout)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      stat        <= SAOK;
      icode_q     <= IHALT;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (run_i) state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready_i) begin
            icode_q <= icode_i;
            if (imem_error_i) begin
              stat  <= SADR;
              state <= S_HALT;
            end else if (!instr_valid_i) begin
              stat  <= SINS;
              state <= S_HALT;
            end else begin
              state <= S_DECODE;
            end
          end else if (timeout) begin
            stat  <= SADR;
            state <= S_HALT;
          end
        end
        S_DECODE:  state <= S_EXECUTE;
        S_EXECUTE: state <= (is_mem_read(icode_q) || is_mem_write(icode_q)) ? S_MEMORY : S_WRITE_BACK;
        S_MEMORY: begin
          if (mem_ready_i) begin
            if (dmem_error_i) begin
              stat  <= SADR;
              state <= S_HALT;
            end else begin
              state <= S_WRITE_BACK;
            end
          end else if (timeout) begin
            stat  <= SADR;
            state <= S_HALT;
          end
        end
        S_WRITE_BACK: state <= S_UPDATE_PC;
        S_UPDATE_PC: begin
          instr_count <= instr_count + CNT_W'(1);
          if (icode_q == IHALT) begin
            stat  <= SHLT;
            state <= S_HALT;
          end else begin
            state <= run_i ? S_FETCH : S_IDLE;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    fetch_en_o             = 1'b0;
    decode_en_o            = 1'b0;
    execute_en_o           = 1'b0;
    memory_en_o            = 1'b0;
    wb_en_o                = 1'b0;
    pc_en_o                = 1'b0;
    ram_read_en_o          = 1'b0;
    ram_write_en_o         = 1'b0;
    ram_read_instruction_o = 1'b0;
    addr_sel_o             = 1'b0;
    case (state)
      S_FETCH: begin
        ram_read_en_o          = 1'b1;
        ram_read_instruction_o = 1'b1;
        fetch_en_o             = mem_ready_i;
      end
      S_DECODE:  decode_en_o  = 1'b1;
      S_EXECUTE: execute_en_o = 1'b1;
      S_MEMORY: begin
        addr_sel_o     = 1'b1;
        ram_read_en_o  = is_mem_read(icode_q);
        ram_write_en_o = is_mem_write(icode_q);
        memory_en_o    = mem_ready_i;
      end
      S_WRITE_BACK: wb_en_o = 1'b1;
      S_UPDATE_PC:  pc_en_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o       = state;
  assign stat_o        = stat;
  assign halted_o      = (state == S_HALT);
  assign instr_count_o = instr_count;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios plus randomized instruction
// streams compared against a per-instruction expected-trace model.
module tb_cpu_seq_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic [3:0]  icode_i = 4'h0;
  logic        instr_valid_i = 1'b1;
  logic        imem_error_i = 1'b0;
  logic        dmem_error_i = 1'b0;
  logic [2:0]  state_o;
  logic        fetch_en_o, decode_en_o, execute_en_o, memory_en_o, wb_en_o, pc_en_o;
  logic        ram_read_en_o, ram_write_en_o, ram_read_instruction_o, addr_sel_o, halted_o;
  logic [2:0]  stat_o;
  logic [31:0] instr_count_o;

  int n_vec = 0;
  int n_err = 0;

  cpu_seq_ctrl #(.MEM_TIMEOUT(TO), .WAIT_W(8), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .run_i(run_i), .mem_ready_i(mem_ready_i),
    .icode_i(icode_i), .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i),
    .dmem_error_i(dmem_error_i), .state_o(state_o), .fetch_en_o(fetch_en_o),
    .decode_en_o(decode_en_o), .execute_en_o(execute_en_o), .memory_en_o(memory_en_o),
    .wb_en_o(wb_en_o), .pc_en_o(pc_en_o), .ram_read_en_o(ram_read_en_o),
    .ram_write_en_o(ram_write_en_o), .ram_read_instruction_o(ram_read_instruction_o),
    .addr_sel_o(addr_sel_o), .stat_o(stat_o), .halted_o(halted_o),
    .instr_count_o(instr_count_o)
  );

  always #5 clk_i = ~clk_i;

  // One cycle: apply inputs just after the rising edge, return at the falling edge.
  task automatic tick(input logic rst, input logic run, input logic rdy, input logic [3:0] ic,
                      input logic ierr, input logic inval, input logic derr);
    @(posedge clk_i);
    #1;
    rst_n = rst; run_i = run; mem_ready_i = rdy; icode_i = ic;
    imem_error_i = ierr; instr_valid_i = ~inval; dmem_error_i = derr;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [10:0] obs_ctrl();
    return {fetch_en_o, decode_en_o, execute_en_o, memory_en_o, wb_en_o, pc_en_o,
            ram_read_en_o, ram_write_en_o, ram_read_instruction_o, addr_sel_o, halted_o};
  endfunction

  function automatic bit mem_rd(input logic [3:0] ic);
    return ic inside {4'h5, 4'h9, 4'hB};
  endfunction

  function automatic bit mem_wr(input logic [3:0] ic);
    return ic inside {4'h4, 4'h8, 4'hA};
  endfunction

  // Expected control bundle for a state, straight from the per-state output rules.
  function automatic logic [10:0] exp_ctrl(input logic [2:0] st, input logic [3:0] ic, input logic rdy);
    logic f, d, x, m, w, p, rr, rw, ri, as, h;
    {f, d, x, m, w, p, rr, rw, ri, as, h} = '0;
    case (st)
      3'd0: begin f = rdy; rr = 1'b1; ri = 1'b1; end
      3'd1: d = 1'b1;
      3'd2: x = 1'b1;
      3'd3: begin m = rdy; as = 1'b1; rr = mem_rd(ic); rw = mem_wr(ic); end
      3'd4: w = 1'b1;
      3'd5: p = 1'b1;
      3'd7: h = 1'b1;
      default: ;
    endcase
    return {f, d, x, m, w, p, rr, rw, ri, as, h};
  endfunction

  typedef struct packed {
    logic [2:0]  st;
    logic        rdy, ierr, inval, derr, run;
    logic [3:0]  ic;
    logic [2:0]  stat;
    logic [31:0] cnt;
  } rec_t;

  rec_t        trace[$];
  logic [2:0]  m_stat;
  logic [31:0] m_cnt;

  function automatic void push(input logic [2:0] st, input logic rdy, input logic ierr,
                               input logic inval, input logic derr, input logic run, input logic [3:0] ic);
    rec_t r;
    r.st = st; r.rdy = rdy; r.ierr = ierr; r.inval = inval; r.derr = derr; r.run = run;
    r.ic = ic; r.stat = m_stat; r.cnt = m_cnt;
    trace.push_back(r);
  endfunction

  // Appends the expected cycles of one instruction starting in FETCH.
  function automatic bit build_instr(input logic [3:0] ic, input int fw, input int mw,
                                     input logic ierr, input logic inval, input logic derr,
                                     input logic run_after);
    for (int k = 0; k < fw && k < TO; k++) push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ic);
    if (fw >= TO) begin m_stat = 3'd3; return 1'b1; end
    push(3'd0, 1'b1, ierr, inval, 1'b0, 1'b0, ic);
    if (ierr)  begin m_stat = 3'd3; return 1'b1; end
    if (inval) begin m_stat = 3'd4; return 1'b1; end
    push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ic);
    push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ic);
    if (mem_rd(ic) || mem_wr(ic)) begin
      for (int k = 0; k < mw && k < TO; k++) push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ic);
      if (mw >= TO) begin m_stat = 3'd3; return 1'b1; end
      push(3'd3, 1'b1, 1'b0, 1'b0, derr, 1'b0, ic);
      if (derr) begin m_stat = 3'd3; return 1'b1; end
    end
    push(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ic);
    push(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, run_after, ic);
    m_cnt = m_cnt + 32'd1;
    if (ic == 4'h0) begin m_stat = 3'd2; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++; if (state_o !== 3'd6) begin n_err++; $display("FAIL reset_state: got %0d expected 6", state_o); end
    n_vec++; if (obs_ctrl() !== 11'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 000", obs_ctrl()); end
    n_vec++; if (stat_o !== 3'd1) begin n_err++; $display("FAIL reset_stat: got %0d expected 1", stat_o); end
    n_vec++; if (instr_count_o !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", instr_count_o); end
  endtask

  task automatic test_halt_prog();
    logic [2:0] seq [12] = '{3'd6, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7};
    int wb_n = 0, wr_n = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b1, 1'b1, (k < 6) ? 4'h3 : 4'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (state_o !== seq[k]) begin n_err++; $display("FAIL prog_state[%0d]: got %0d expected %0d", k, state_o, seq[k]); end
      wb_n += int'(wb_en_o);
      wr_n += int'(ram_write_en_o);
    end
    n_vec++; if (wb_n != 2) begin n_err++; $display("FAIL prog_wb_pulses: got %0d expected 2", wb_n); end
    n_vec++; if (wr_n != 0) begin n_err++; $display("FAIL prog_write: got %0d expected 0", wr_n); end
    n_vec++; if (stat_o !== 3'd2) begin n_err++; $display("FAIL prog_stat: got %0d expected 2", stat_o); end
    n_vec++; if (instr_count_o !== 32'd2) begin n_err++; $display("FAIL prog_count: got %0d expected 2", instr_count_o); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b1, (j == 2), 4'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({state_o, ram_write_en_o, ram_read_en_o, addr_sel_o, memory_en_o} !== {3'd3, 1'b1, 1'b0, 1'b1, (j == 2)}) begin
        n_err++;
        $display("FAIL memwait[%0d]: got st=%0d wr=%b rd=%b as=%b men=%b expected st=3 wr=1 rd=0 as=1 men=%b",
                 j, state_o, ram_write_en_o, ram_read_en_o, addr_sel_o, memory_en_o, (j == 2));
      end
    end
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (state_o !== 3'd4) begin n_err++; $display("FAIL memwait_wb: got %0d expected 4", state_o); end
  endtask

  task automatic test_dmem_err();
    int bad = 0;
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    n_vec++; if ({state_o, ram_read_en_o} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL dmem_read: got st=%0d rd=%b expected st=3 rd=1", state_o, ram_read_en_o); end
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
      bad += int'(wb_en_o) + int'(pc_en_o);
    end
    n_vec++; if (state_o !== 3'd7) begin n_err++; $display("FAIL dmem_state: got %0d expected 7", state_o); end
    n_vec++; if (stat_o !== 3'd3) begin n_err++; $display("FAIL dmem_stat: got %0d expected 3", stat_o); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL dmem_no_retire: got %0d strobes expected 0", bad); end
    n_vec++; if (instr_count_o !== 32'd0) begin n_err++; $display("FAIL dmem_count: got %0d expected 0", instr_count_o); end
  endtask

  task automatic test_fetch_err();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 4'h6, (v == 0), 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({state_o, stat_o} !== {3'd7, (v == 0) ? 3'd3 : 3'd4}) begin
        n_err++;
        $display("FAIL fetch_err[%0d]: got st=%0d stat=%0d expected st=7 stat=%0d", v, state_o, stat_o, (v == 0) ? 3 : 4);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < TO; j++) begin
      tick(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL timeout_wait[%0d]: got %0d expected 0", j, state_o); end
    end
    tick(1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    n_vec++; if ({state_o, stat_o} !== {3'd7, 3'd3}) begin n_err++; $display("FAIL timeout_halt: got st=%0d stat=%0d expected st=7 stat=3", state_o, stat_o); end
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < TO; j++) tick(1'b1, 1'b1, (j == TO - 1), 4'h1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if ({state_o, stat_o} !== {3'd1, 3'd1}) begin n_err++; $display("FAIL timeout_ready_wins: got st=%0d stat=%0d expected st=1 stat=1", state_o, stat_o); end
  endtask

  task automatic test_stop_reset();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (state_o !== 3'd5) begin n_err++; $display("FAIL stop_upc: got %0d expected 5", state_o); end
    for (int j = 0; j < 2; j++) begin
      tick(1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({state_o, obs_ctrl(), instr_count_o} !== {3'd6, 11'h0, 32'd1}) begin
        n_err++;
        $display("FAIL stop_idle[%0d]: got st=%0d ctrl=%h cnt=%0d expected st=6 ctrl=000 cnt=1", j, state_o, obs_ctrl(), instr_count_o);
      end
    end
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if ({state_o, ram_write_en_o} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL rst_mem_pre: got st=%0d wr=%b expected st=3 wr=1", state_o, ram_write_en_o); end
    tick(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({state_o, obs_ctrl(), instr_count_o, stat_o} !== {3'd6, 11'h0, 32'd0, 3'd1}) begin
      n_err++;
      $display("FAIL rst_mem_post: got st=%0d ctrl=%h cnt=%0d stat=%0d expected st=6 ctrl=000 cnt=0 stat=1", state_o, obs_ctrl(), instr_count_o, stat_o);
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 40; ep++) begin
      bit halted = 1'b0;
      bit run_after = 1'b1;
      do_reset();
      trace.delete();
      m_stat = 3'd1;
      m_cnt  = 32'd0;
      push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      for (int n = 0; n < 6 && !halted; n++) begin
        logic [3:0] ic = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
        int fw = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, 2));
        int mw = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, 2));
        if (!run_after) push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        run_after = 1'($urandom_range(0, 1));
        halted = build_instr(ic, fw, mw, ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
                             ($urandom_range(0, 11) == 0), run_after);
      end
      if (halted) begin
        push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      end
      foreach (trace[i]) begin
        rec_t r = trace[i];
        logic acc_f = (r.st == 3'd0) && r.rdy;
        logic acc_m = (r.st == 3'd3) && r.rdy;
        logic rdy = (r.st == 3'd0 || r.st == 3'd3) ? r.rdy : 1'($urandom);
        logic run = (r.st == 3'd5 || r.st == 3'd6) ? r.run : 1'($urandom);
        tick(1'b1, run, rdy, acc_f ? r.ic : 4'($urandom), acc_f ? r.ierr : 1'($urandom),
             acc_f ? r.inval : 1'($urandom), acc_m ? r.derr : 1'($urandom));
        n_vec++;
        if ({state_o, obs_ctrl(), stat_o, instr_count_o} !== {r.st, exp_ctrl(r.st, r.ic, rdy), r.stat, r.cnt}) begin
          n_err++;
          $display("FAIL rand ep%0d cyc%0d: got st=%0d ctrl=%h stat=%0d cnt=%0d expected st=%0d ctrl=%h stat=%0d cnt=%0d",
                   ep, i, state_o, obs_ctrl(), stat_o, instr_count_o, r.st, exp_ctrl(r.st, r.ic, rdy), r.stat, r.cnt);
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt_prog();
    test_mem_wait();
    test_dmem_err();
    test_fetch_err();
    test_timeout();
    test_stop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 datapath (fetch, decode, regfile, ALU, ram).
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITE_BACK and UPDATE_PC.
- Issues per-stage latch/enable pulses and drives the ram request controls and the address-source select.
- Waits on a memory-ready handshake, tracks architectural status (AOK/HLT/ADR/INS) and counts retired instructions.
- Replaces the inline state logic in cpu_top.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready_i before ADR fault; 0 disables the timeout
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT
CNT_W, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  clock
rst_n  in  1  reset, synchronous, active-low
run_i  in  1  1 = free-run; 0 = stop in IDLE after the current instruction
mem_ready_i  in  1  ram completes the current request this cycle
icode_i  in  4  icode from fetch, sampled on accept
instr_valid_i  in  1  fetch decoded a legal instruction
imem_error_i  in  1  instruction address fault
dmem_error_i  in  1  data address fault
state_o  out  3  current state
fetch_en_o  out  1  latch fetch outputs
decode_en_o  out  1  decode/regfile read strobe
execute_en_o  out  1  ALU/CC update strobe
memory_en_o  out  1  latch valM
wb_en_o  out  1  regfile write enable
pc_en_o  out  1  PC <= new PC
ram_read_en_o  out  1  ram read request
ram_write_en_o  out  1  ram write request
ram_read_instruction_o  out  1  read is a 10-byte instruction fetch
addr_sel_o  out  1  0 = PC, 1 = data address (valE/valA)
stat_o  out  3  1 AOK, 2 HLT, 3 ADR, 4 INS
halted_o  out  1  state == HALT
instr_count_o  out  CNT_W  retired instructions

Behaviour:
- Reset: synchronous; rst_n low at a clock edge gives state=IDLE, stat=AOK, icode latch=0, wait counter=0, instr_count=0. This applies from any state, including mid-MEMORY; no write or PC update occurs after that edge.
- All outputs are decoded combinationally from registered state. Therefore during and after reset every enable and request is 0, addr_sel_o=0 and halted_o=0.
- State codes: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITE_BACK=4, UPDATE_PC=5, IDLE=6, HALT=7.
- Memory-op classes:
  - Read: IMRMOVQ(5), IRET(9), IPOPQ(B).
  - Write: IRMMOVQ(4), ICALL(8), IPUSHQ(A).
  - All other icodes skip MEMORY.
- IDLE: no outputs asserted. run_i=1 → FETCH.
- FETCH:
  - Drive ram_read_en_o=1, ram_read_instruction_o=1, addr_sel_o=0.
  - fetch_en_o = mem_ready_i.
  - On mem_ready_i: latch icode_i, then resolve in this priority order:
    - imem_error_i → stat=ADR, HALT.
    - else !instr_valid_i → stat=INS, HALT.
    - else → DECODE.
- DECODE: decode_en_o=1 for one cycle → EXECUTE.
- EXECUTE: execute_en_o=1 for one cycle → MEMORY if the latched icode is a memory op, else WRITE_BACK.
- MEMORY:
  - Drive addr_sel_o=1, plus ram_read_en_o (read class) or ram_write_en_o (write class); never both.
  - memory_en_o = mem_ready_i.
  - On mem_ready_i: dmem_error_i → stat=ADR, HALT (no WB, no PC update); else → WRITE_BACK.
- WRITE_BACK: wb_en_o=1 for one cycle → UPDATE_PC.
- UPDATE_PC:
  - pc_en_o=1; instr_count increments (wraps modulo 2^CNT_W).
  - icode==IHALT(0) → stat=HLT, HALT.
  - else run_i=1 → FETCH; run_i=0 → IDLE.
- HALT: absorbing, all enables 0, halted_o=1, stat held; exit only by reset.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY; increments each cycle in those states with mem_ready_i=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 with mem_ready_i=0 → stat=ADR, HALT.
  - If mem_ready_i=1 in the same cycle, ready wins.
- Latency with zero-wait memory: non-memory instruction 5 cycles, memory instruction 6 cycles.
- stat_o changes only on the transition into HALT. run_i is sampled only in IDLE and UPDATE_PC.

Decomposition:
- Shared package y86_pkg:
  - icode constants IHALT..IPOPQ.
  - state codes.
  - stat codes SAOK/SHLT/SADR/SINS.
  - functions is_mem_read(icode) and is_mem_write(icode).
- One sub-module, mem_wait_timer: the wait counter with clear/enable inputs and a timeout output.

Test Plan:
1. run_i=1, mem_ready_i=1, icode 3 (irmovq) then 0 (halt) → states 6,0,1,2,4,5,0,1,2,4,5,7; instr_count_o=2; stat_o=2; wb_en_o pulsed twice; ram_write_en_o never asserted.
2. icode 4 (rmmovq), mem_ready_i low 2 cycles in MEMORY → ram_write_en_o=1 and addr_sel_o=1 for 3 cycles; memory_en_o pulses on the 3rd cycle; then WRITE_BACK.
3. icode 5 with dmem_error_i=1 at ready → HALT, stat_o=3, no wb_en_o or pc_en_o pulse, instr_count_o unchanged.
4. FETCH with imem_error_i=1 and instr_valid_i=0 together → stat_o=3 (ADR priority). Separately, instr_valid_i=0 alone → stat_o=4.
5. MEM_TIMEOUT=4, mem_ready_i held 0 in FETCH → HALT after exactly 4 FETCH cycles, stat_o=3. Repeat with ready asserted on the 4th cycle → DECODE.
6. run_i=0 at UPDATE_PC → IDLE, outputs quiet. rst_n=0 for one edge while in MEMORY → IDLE next cycle, instr_count_o=0, ram requests drop.
